// File: rtl/mul_share_arbiter.sv
// ---------------------------------------------------------------------------
// mul_share_arbiter
//
// Shares one external pipelined unsigned multiplier among N_REQ requesters.
// Each granted operand pair is registered onto o_mul_a/o_mul_b. The owner id
// rides a shadow tag pipeline (MUL_LAT+1 stages, never stalled), so every
// product returns to the requester that issued it. Results come back in issue
// order and are never backpressured.
//
// Build option:
//   MUL_ARB_FIXED_PRIO_EN  defined  -> lowest-index valid requester wins
//                          undefined -> round-robin starting after last grant
//
// Ports:
//   i_clk, i_rst      clock (rising edge), synchronous active-high reset
//   i_ena             grant enable; in-flight operations drain regardless
//   i_req_valid       per-requester request
//   i_req_a/i_req_b   packed operands, requester i at [i*W +: W]
//   o_req_ready       one-hot grant (combinational)
//   o_mul_a/o_mul_b   registered operands to the multiplier
//   i_mul_p           multiplier product, valid MUL_LAT cycles after operands
//   o_rsp_valid       one-hot registered result strobe
//   o_rsp_p           result value
//   o_rsp_id          owner of the current result
//   o_busy            any tag stage valid
// ---------------------------------------------------------------------------
module mul_share_arbiter #(
    parameter  int N_REQ   = 4,
    parameter  int W       = 4,
    parameter  int MUL_LAT = 2,
    localparam int IDW     = $clog2(N_REQ)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_ena,
    input  logic [N_REQ-1:0]     i_req_valid,
    input  logic [N_REQ*W-1:0]   i_req_a,
    input  logic [N_REQ*W-1:0]   i_req_b,
    output logic [N_REQ-1:0]     o_req_ready,
    output logic [W-1:0]         o_mul_a,
    output logic [W-1:0]         o_mul_b,
    input  logic [2*W-1:0]       i_mul_p,
    output logic [N_REQ-1:0]     o_rsp_valid,
    output logic [2*W-1:0]       o_rsp_p,
    output logic [IDW-1:0]       o_rsp_id,
    output logic                 o_busy
);

    // Packed per-requester views; the slice order matches [i*W +: W].
    logic [N_REQ-1:0][W-1:0] w_a;
    logic [N_REQ-1:0][W-1:0] w_b;
    assign w_a = i_req_a;
    assign w_b = i_req_b;

    logic [N_REQ-1:0]          w_gnt;
    logic [IDW-1:0]            w_gid;
    logic                      w_found;
    logic                      w_hs;

    logic [W-1:0]              r_mul_a;
    logic [W-1:0]              r_mul_b;
    logic [MUL_LAT:0]          r_vld_pipe;
    logic [MUL_LAT:0][IDW-1:0] r_id_pipe;
    logic [N_REQ-1:0]          r_rsp_valid;
    logic [2*W-1:0]            r_rsp_p;
    logic [IDW-1:0]            r_rsp_id;

`ifndef MUL_ARB_FIXED_PRIO_EN
    logic [IDW-1:0]            r_last;
`endif

    // Grant selection.
    always_comb begin
        w_gnt   = '0;
        w_gid   = '0;
        w_found = 1'b0;
`ifdef MUL_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_found && i_req_valid[i]) begin
                w_found  = 1'b1;
                w_gnt[i] = 1'b1;
                w_gid    = IDW'(i);
            end
        end
`else
        // Two ascending passes implement the rotating search: first the
        // requesters above last, then wrap around from index 0 (which also
        // picks last itself when it is the only one valid).
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_found && i_req_valid[i] && (IDW'(i) > r_last)) begin
                w_found  = 1'b1;
                w_gnt[i] = 1'b1;
                w_gid    = IDW'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_found && i_req_valid[i]) begin
                w_found  = 1'b1;
                w_gnt[i] = 1'b1;
                w_gid    = IDW'(i);
            end
        end
`endif
    end

    // Reset masks the grant so nothing is accepted on a reset edge.
    assign o_req_ready = (i_ena && !i_rst) ? w_gnt : '0;
    assign w_hs        = |(i_req_valid & o_req_ready);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_vld_pipe  <= '0;
            r_id_pipe   <= '0;
            r_rsp_valid <= '0;
            r_rsp_p     <= '0;
            r_rsp_id    <= '0;
`ifndef MUL_ARB_FIXED_PRIO_EN
            r_last      <= IDW'(N_REQ - 1);
`endif
        end else begin
            if (w_hs) begin
                r_mul_a <= w_a[w_gid];
                r_mul_b <= w_b[w_gid];
`ifndef MUL_ARB_FIXED_PRIO_EN
                r_last  <= w_gid;
`endif
            end

            // Tag pipeline shifts every cycle; stage 0 captures this cycle's
            // issue (or a bubble).
            r_vld_pipe <= {r_vld_pipe[MUL_LAT-1:0], w_hs};
            r_id_pipe  <= {r_id_pipe[MUL_LAT-1:0], w_gid};

            // The last tag stage lines up with the product on i_mul_p.
            r_rsp_valid <= '0;
            if (r_vld_pipe[MUL_LAT]) begin
                r_rsp_valid[r_id_pipe[MUL_LAT]] <= 1'b1;
                r_rsp_p                         <= i_mul_p;
                r_rsp_id                        <= r_id_pipe[MUL_LAT];
            end
        end
    end

    assign o_mul_a     = r_mul_a;
    assign o_mul_b     = r_mul_b;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_p     = r_rsp_p;
    assign o_rsp_id    = r_rsp_id;
    assign o_busy      = |r_vld_pipe;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter (N_REQ=4, W=4, MUL_LAT=2). The bench
// supplies a two-stage multiplier model behind o_mul_a/o_mul_b.
module tb_mul_share_arbiter;
    localparam int N = 4;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           ena;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   mul_a;
    logic [W-1:0]   mul_b;
    logic [2*W-1:0] mul_p;
    logic [N-1:0]   rsp_valid;
    logic [2*W-1:0] rsp_p;
    logic [1:0]     rsp_id;
    logic           busy;

    int checks   = 0;
    int failures = 0;

    logic [7:0] rr_prod [4];
    logic [3:0] exp_v;
    logic [7:0] exp_p;

    mul_share_arbiter #(.N_REQ(N), .W(W), .MUL_LAT(2)) dut (
        .i_clk(clk), .i_rst(rst), .i_ena(ena),
        .i_req_valid(req_valid), .i_req_a(req_a), .i_req_b(req_b),
        .o_req_ready(req_ready), .o_mul_a(mul_a), .o_mul_b(mul_b),
        .i_mul_p(mul_p), .o_rsp_valid(rsp_valid), .o_rsp_p(rsp_p),
        .o_rsp_id(rsp_id), .o_busy(busy)
    );

    always #5 clk = ~clk;

    // Multiplier model: product valid two edges after the registered operands.
    logic [7:0] p1, p2;
    always @(posedge clk) begin
        p1 <= {4'b0, mul_a} * {4'b0, mul_b};
        p2 <= p1;
    end
    assign mul_p = p2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ena = 1'b1; req_valid = 4'hF; req_a = '0; req_b = '0;
        tick(); tick();
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
        checks++; if (mul_a !== 4'd0 || mul_b !== 4'd0) begin failures++; $display("FAIL reset_mul got=%0d,%0d exp=0,0", mul_a, mul_b); end
        checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0000", rsp_valid); end
        checks++; if (rsp_p !== 8'd0 || rsp_id !== 2'd0) begin failures++; $display("FAIL reset_rsp got p=%0d id=%0d exp p=0 id=0", rsp_p, rsp_id); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst = 1'b0; req_valid = '0;
    endtask

    task automatic test_single();
        req_a[3:0] = 4'd3; req_b[3:0] = 4'd5; req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_ready got=%b exp=0001", req_ready); end
        tick(); req_valid = '0;
        checks++; if (mul_a !== 4'd3 || mul_b !== 4'd5) begin failures++; $display("FAIL single_mul got=%0d,%0d exp=3,5", mul_a, mul_b); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (busy !== 1'b1 || rsp_valid !== 4'b0000) begin failures++; $display("FAIL single_busy step=%0d got busy=%b rv=%b exp busy=1 rv=0000", k, busy, rsp_valid); end
            tick();
        end
        checks++; if (rsp_valid !== 4'b0001 || rsp_p !== 8'd15 || rsp_id !== 2'd0) begin failures++; $display("FAIL single_rsp got rv=%b p=%0d id=%0d exp rv=0001 p=15 id=0", rsp_valid, rsp_p, rsp_id); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_end got=%b exp=0", busy); end
        tick();
        checks++; if (rsp_valid !== 4'b0000 || rsp_p !== 8'd15) begin failures++; $display("FAIL single_hold got rv=%b p=%0d exp rv=0000 p=15", rsp_valid, rsp_p); end
    endtask

    task automatic test_round_robin();
        do_reset();
        rr_prod[0] = 8'd2; rr_prod[1] = 8'd6; rr_prod[2] = 8'd12; rr_prod[3] = 8'd20;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = 4'(i + 1);
            req_b[i*W +: W] = 4'(i + 2);
        end
        for (int k = 0; k < 11; k++) begin
            if (k < 8) begin
                req_valid = 4'hF; #1;
                exp_v = 4'b0001 << (k % 4);
                checks++; if (req_ready !== exp_v) begin failures++; $display("FAIL rr_ready cyc=%0d got=%b exp=%b", k, req_ready, exp_v); end
            end else begin
                req_valid = '0;
            end
            tick();
            if (k < 8) begin
                checks++; if (mul_a !== 4'((k % 4) + 1)) begin failures++; $display("FAIL rr_mul_a cyc=%0d got=%0d exp=%0d", k, mul_a, (k % 4) + 1); end
            end
            if (k >= 3) begin
                exp_v = 4'b0001 << ((k - 3) % 4);
                exp_p = rr_prod[(k - 3) % 4];
                checks++; if (rsp_valid !== exp_v || rsp_p !== exp_p || rsp_id !== 2'((k - 3) % 4)) begin failures++; $display("FAIL rr_rsp cyc=%0d got rv=%b p=%0d id=%0d exp rv=%b p=%0d id=%0d", k, rsp_valid, rsp_p, rsp_id, exp_v, exp_p, (k - 3) % 4); end
            end else begin
                checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL rr_rsp_early cyc=%0d got=%b exp=0000", k, rsp_valid); end
            end
        end
    endtask

    // Last grant was 3: requester 2 (max) then requester 3 (zero operand).
    task automatic test_extremes();
        req_a[11:8] = 4'd15; req_b[11:8] = 4'd15; req_valid = 4'b0100; #1;
        checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL max_ready got=%b exp=0100", req_ready); end
        tick(); req_valid = '0;
        tick(); tick(); tick();
        checks++; if (rsp_valid !== 4'b0100 || rsp_p !== 8'd225 || rsp_id !== 2'd2) begin failures++; $display("FAIL max_rsp got rv=%b p=%0d id=%0d exp rv=0100 p=225 id=2", rsp_valid, rsp_p, rsp_id); end
        req_a[15:12] = 4'd0; req_b[15:12] = 4'd9; req_valid = 4'b1000; #1;
        checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL zero_ready got=%b exp=1000", req_ready); end
        tick(); req_valid = '0;
        tick(); tick(); tick();
        checks++; if (rsp_valid !== 4'b1000 || rsp_p !== 8'd0 || rsp_id !== 2'd3) begin failures++; $display("FAIL zero_rsp got rv=%b p=%0d id=%0d exp rv=1000 p=0 id=3", rsp_valid, rsp_p, rsp_id); end
    endtask

    task automatic test_reset_midflight();
        req_a[3:0] = 4'd1; req_b[3:0] = 4'd1; req_a[7:4] = 4'd2; req_b[7:4] = 4'd2;
        req_valid = 4'b0011; #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL mid_ready0 got=%b exp=0001", req_ready); end
        tick(); #1;
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL mid_ready1 got=%b exp=0010", req_ready); end
        tick();
        rst = 1'b1; req_valid = 4'hF; #1;
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL mid_ready_rst got=%b exp=0000", req_ready); end
        tick();
        rst = 1'b0; req_valid = '0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL mid_no_rsp step=%0d got=%b exp=0000", k, rsp_valid); end
            tick();
        end
        req_valid = 4'hF; #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL mid_next_grant got=%b exp=0001", req_ready); end
        tick(); req_valid = '0;
        tick(); tick(); tick();
        checks++; if (rsp_valid !== 4'b0001 || rsp_p !== 8'd1) begin failures++; $display("FAIL mid_after_rsp got rv=%b p=%0d exp rv=0001 p=1", rsp_valid, rsp_p); end
    endtask

    task automatic test_ena_low();
        ena = 1'b0; req_a[11:8] = 4'd7; req_b[11:8] = 4'd6; req_valid = 4'b0100;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL ena_low_ready step=%0d got=%b exp=0000", k, req_ready); end
            tick();
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ena_low_busy got=%b exp=0", busy); end
        ena = 1'b1; #1;
        checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL ena_rise_ready got=%b exp=0100", req_ready); end
        tick();
        ena = 1'b0; #1;
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL ena_drop_ready got=%b exp=0000", req_ready); end
        tick(); tick(); tick();
        checks++; if (rsp_valid !== 4'b0100 || rsp_p !== 8'd42 || rsp_id !== 2'd2) begin failures++; $display("FAIL ena_drain_rsp got rv=%b p=%0d id=%0d exp rv=0100 p=42 id=2", rsp_valid, rsp_p, rsp_id); end
        req_valid = '0; ena = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        req_b[7:4] = 4'd4;
        for (int k = 0; k < 6; k++) begin
            if (k < 3) begin
                req_a[7:4] = 4'(k + 1); req_valid = 4'b0010; #1;
                checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL b2b_ready cyc=%0d got=%b exp=0010", k, req_ready); end
            end else begin
                req_valid = '0;
            end
            tick();
            if (k >= 3) begin
                exp_p = 8'(4 * (k - 2));
                checks++; if (rsp_valid !== 4'b0010 || rsp_p !== exp_p) begin failures++; $display("FAIL b2b_rsp cyc=%0d got rv=%b p=%0d exp rv=0010 p=%0d", k, rsp_valid, rsp_p, exp_p); end
            end else begin
                checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL b2b_rsp_early cyc=%0d got=%b exp=0000", k, rsp_valid); end
            end
        end
    endtask

    task automatic test_fixed_prio();
        do_reset();
        req_valid = 4'b1010;
        for (int k = 0; k < 6; k++) begin
            #1;
`ifdef MUL_ARB_FIXED_PRIO_EN
            exp_v = 4'b0010;
`else
            exp_v = (k % 2 == 0) ? 4'b0010 : 4'b1000;
`endif
            checks++; if (req_ready !== exp_v) begin failures++; $display("FAIL prio_ready cyc=%0d got=%b exp=%b", k, req_ready, exp_v); end
            tick();
        end
        req_valid = '0;
        repeat (4) tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL prio_drain_busy got=%b exp=0", busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_extremes();
        test_reset_midflight();
        test_ena_low();
        test_back_to_back();
        test_fixed_prio();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mul_share_arbiter.md
# mul_share_arbiter

Round-robin arbiter that shares one pipelined unsigned multiplier among `N_REQ` requesters. Each accepted operand pair is issued into the multiplier. A matching requester-ID tag travels alongside it through a shadow pipeline, so the product returns with the correct owner. The block sits between the requester ports and the multiplier instance, and is the only driver of the multiplier inputs.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, 2..8.
- `W`, default 4: operand width; product width is 2W.
- `MUL_LAT`, default 2: multiplier latency in cycles, from registered `mul_a`/`mul_b` to valid `mul_p`; minimum 1.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `ena`  in  1: when low, no new grants; in-flight operations still drain.
- `req_valid`  in  N_REQ: per-requester request.
- `req_a`  in  N_REQ*W: packed operand A; requester i uses slice `[i*W +: W]`.
- `req_b`  in  N_REQ*W: packed operand B, same packing as `req_a`.
- `req_ready`  out  N_REQ: one-hot grant, combinational.
- `mul_a`, `mul_b`  out  W: registered operands to the multiplier.
- `mul_p`  in  2W: multiplier product.
- `rsp_valid`  out  N_REQ: one-hot result strobe, registered.
- `rsp_p`  out  2W: result value.
- `rsp_id`  out  clog2(N_REQ): owner of the current result.
- `busy`  out  1: high while any operation is in flight.

## Operation
- **Grant rule.** When `ena`=1 and any `req_valid` is set, exactly one `req_ready` bit is asserted: the first valid requester searched from `last+1`, wrapping modulo N_REQ.
- **Requester obligations.** Operands must be held stable until `req_valid & req_ready`. Dropping `req_valid` before the grant is legal.
- **Handshake commit.** On a handshake at a clock edge:
  - `mul_a`/`mul_b` load the granted operands.
  - The tag pipeline stage 0 loads `{1, id}`.
  - `last` is set to the granted id.
- **No handshake.** Stage 0 valid is loaded with 0. `mul_a`/`mul_b` hold their last values.
- **Tag pipeline.** MUL_LAT+1 stages of `{valid, id}`, shifted every cycle and never stalled. There is no backpressure on responses; requesters must accept `rsp_valid` unconditionally.
- **Result output.** When the last tag stage is valid, the next edge registers:
  - `rsp_p <= mul_p`
  - `rsp_id <= id`
  - `rsp_valid <= onehot(id)`

  Otherwise `rsp_valid <= 0`, and `rsp_p`/`rsp_id` hold their values.
- **Throughput and ordering.** One issue per cycle; results return in issue order.
- **`busy`.** OR of all tag-stage valid bits.
- **Reset values:**
  - `mul_a` = 0, `mul_b` = 0
  - `rsp_valid` = 0, `rsp_p` = 0, `rsp_id` = 0
  - all tag valid bits = 0, so `busy` = 0
  - `last` = N_REQ-1, so requester 0 has first priority

  `req_ready` is 0 while `rst` is high.
- **Reset mid-operation.** All in-flight operations are discarded, and no `rsp_valid` is produced for them.
- **`ena` dropped mid-stream.** Stops grants the same cycle. Already-issued results still appear on schedule.

## Timing
- Grant is combinational, in the same cycle as `req_valid`.
- Handshake at edge E: the product is visible on `rsp_p` with `rsp_valid` high during the cycle after edge E+MUL_LAT+1. That is a latency of MUL_LAT+2 edges; 4 for the default.
- A requester re-asserting `req_valid` back-to-back is granted again only when no other requester is valid. A single active requester gets one grant per cycle.
- Simultaneous handshake and result output in the same cycle is the normal steady state; no conflict is possible.

## Configuration
- **`MUL_ARB_FIXED_PRIO_EN` defined:** the grant goes to the lowest-index valid requester; `last` is not used.
- **Undefined (default):** round-robin as described above.

Ports, latency and the reset values of all outputs are identical in both builds.

## Test plan
- **Single request.** Reset; requester 0 presents a=3, b=5 at edge 0 with `ena`=1.
  - `req_ready`=0001.
  - `rsp_valid`=0001, `rsp_p`=15, `rsp_id`=0 after edge 4.
  - `busy` high from edge 1 through edge 3.
- **Round-robin contention.** All 4 requesters valid continuously, operands (i+1)×(i+2).
  - Grants cycle 0,1,2,3,0…
  - Results return in order: 2, 6, 12, 20, one per cycle.
- **Maximum values.** a=15, b=15 → `rsp_p`=225.
- **Zero operand.** a=0, b=9 → `rsp_p`=0.
- **Reset mid-flight.** Issue 2 requests, assert `rst` for 1 cycle at edge 2.
  - No `rsp_valid` ever appears for them.
  - `busy`=0 after the reset edge.
  - The next grant goes to requester 0.
- **`ena` low.** With `ena`=0, requester 2 valid → `req_ready`=0 for 5 cycles. After `ena` rises, requester 2 is granted in that cycle.
- **Fixed-priority build.** With `MUL_ARB_FIXED_PRIO_EN` defined and requesters 1 and 3 continuously valid, requester 1 wins every cycle.
